// File: rtl/branch_sequencer.sv
// Bicc sequencer: owns the integer condition codes, resolves the decoded branch,
// drives the PC redirect and decides whether the delay-slot instruction is annulled.
module branch_sequencer #(
    parameter int PC_W   = 32,
    parameter int DISP_W = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icc_we,
    input  logic [3:0]        icc_in,
    output logic [3:0]        icc,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        cond,
    input  logic              annul,
    input  logic [DISP_W-1:0] disp,
    input  logic [PC_W-1:0]   pc,
    output logic              redirect,
    output logic [PC_W-1:0]   target,
    output logic              taken,
    output logic              resolved,
    input  logic              slot_issue,
    output logic              slot_kill,
    input  logic              flush
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CCWAIT  = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_SLOT    = 2'd3
    } state_t;

    localparam logic [3:0] COND_BA = 4'b1000;

    state_t            state_r;
    logic [3:0]        icc_r;
    logic [3:0]        cond_r;
    logic              annul_r;
    logic              kill_pending_r;
    logic              br_ready_r;
    logic              resolved_r;
    logic              redirect_r;
    logic              taken_r;
    logic [PC_W-1:0]   target_r;

    logic [3:0]        icc_next_s;
    logic              hs_s;
    logic              eval_s;
    logic [3:0]        eval_cond_s;
    logic              eval_annul_s;
    logic              eval_taken_s;
    logic [PC_W-1:0]   disp_ext_s;
    logic [PC_W-1:0]   target_s;

    // Codes 1xxx are the complements of 0xxx, so only the base predicate is tabulated.
    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cf, base;
        {n, z, v, cf} = f;
        case (c[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = z;
            3'd2:    base = z | (n ^ v);
            3'd3:    base = n ^ v;
            3'd4:    base = cf | z;
            3'd5:    base = cf;
            3'd6:    base = n;
            3'd7:    base = v;
            default: base = 1'b0;
        endcase
        return base ^ c[3];
    endfunction

    // Resolution is computed on the edge entering RESOLVE, against the flags the
    // register will hold during RESOLVE (so a CCWAIT write is seen).
    always_comb begin
        icc_next_s = icc_we ? icc_in : icc_r;
        hs_s       = br_valid & br_ready_r;
        if (state_r == ST_IDLE) begin
            eval_cond_s  = cond;
            eval_annul_s = annul;
        end else begin
            eval_cond_s  = cond_r;
            eval_annul_s = annul_r;
        end
        eval_s       = ((state_r == ST_IDLE) & hs_s & ~icc_we) | (state_r == ST_CCWAIT);
        eval_taken_s = cond_true(eval_cond_s, icc_next_s);
        disp_ext_s   = PC_W'($signed(disp));
        target_s     = pc + {disp_ext_s[PC_W-3:0], 2'b00};
    end

    // Condition-code register: written whenever the ALU asks, independent of flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icc_r <= 4'b0000;
        end else if (icc_we) begin
            icc_r <= icc_in;
        end else begin
            icc_r <= icc_r;
        end
    end

    // Branch sequencing FSM with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cond_r         <= 4'b0000;
            annul_r        <= 1'b0;
            kill_pending_r <= 1'b0;
            br_ready_r     <= 1'b1;
            resolved_r     <= 1'b0;
            redirect_r     <= 1'b0;
            taken_r        <= 1'b0;
            target_r       <= {PC_W{1'b0}};
        end else begin
            resolved_r <= 1'b0;
            redirect_r <= 1'b0;
            if (flush) begin
                state_r        <= ST_IDLE;
                br_ready_r     <= 1'b1;
                kill_pending_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (hs_s) begin
                            cond_r     <= cond;
                            annul_r    <= annul;
                            target_r   <= target_s;
                            br_ready_r <= 1'b0;
                            state_r    <= icc_we ? ST_CCWAIT : ST_RESOLVE;
                        end
                    end
                    ST_CCWAIT:  state_r <= ST_RESOLVE;
                    ST_RESOLVE: state_r <= ST_SLOT;
                    ST_SLOT: begin
                        if (slot_issue) begin
                            state_r        <= ST_IDLE;
                            br_ready_r     <= 1'b1;
                            kill_pending_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        br_ready_r <= 1'b1;
                    end
                endcase
                if (eval_s) begin
                    resolved_r     <= 1'b1;
                    redirect_r     <= eval_taken_s;
                    taken_r        <= eval_taken_s;
                    kill_pending_r <= eval_annul_s & (~eval_taken_s | (eval_cond_s == COND_BA));
                end
            end
        end
    end

    assign icc       = icc_r;
    assign br_ready  = br_ready_r;
    assign taken     = taken_r;
    assign target    = target_r;
    assign resolved  = resolved_r & ~flush;
    assign redirect  = redirect_r & ~flush;
    assign slot_kill = (state_r == ST_SLOT) & slot_issue & kill_pending_r & ~flush;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: a driver issues branches and queues the
// expected outcome from a table-driven reference; a monitor checks every cycle.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icc_we;
    logic [3:0]  icc_in;
    logic [3:0]  icc;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  cond;
    logic        annul;
    logic [21:0] disp;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] target;
    logic        taken;
    logic        resolved;
    logic        slot_issue;
    logic        slot_kill;
    logic        flush;

    branch_sequencer #(.PC_W(32), .DISP_W(22)) dut (
        .clk(clk), .rst_n(rst_n), .icc_we(icc_we), .icc_in(icc_in), .icc(icc),
        .br_valid(br_valid), .br_ready(br_ready), .cond(cond), .annul(annul),
        .disp(disp), .pc(pc), .redirect(redirect), .target(target), .taken(taken),
        .resolved(resolved), .slot_issue(slot_issue), .slot_kill(slot_kill), .flush(flush)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit        tk;
        bit [31:0] tgt;
        int        at;
    } exp_t;

    exp_t       exp_q[$];
    bit         kill_q[$];
    bit         slot_chk = 1'b0;
    bit [3:0]   icc_m = 4'b0000;
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic bit ref_taken(input bit [3:0] c, input bit [3:0] f);
        bit n, z, v, cf;
        n = f[3]; z = f[2]; v = f[1]; cf = f[0];
        case (c)
            4'h0: return 1'b0;
            4'h1: return z;
            4'h2: return z || (n != v);
            4'h3: return n != v;
            4'h4: return cf || z;
            4'h5: return cf;
            4'h6: return n;
            4'h7: return v;
            4'h8: return 1'b1;
            4'h9: return !z;
            4'hA: return !(z || (n != v));
            4'hB: return n == v;
            4'hC: return !(cf || z);
            4'hD: return !cf;
            4'hE: return !n;
            4'hF: return !v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] ref_target(input bit [31:0] p, input bit [21:0] d);
        longint sd;
        longint t;
        sd = longint'(d);
        if (d[21]) sd = sd - 64'sd4194304;
        t = longint'(p) + sd * 64'sd4;
        return t[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just after each falling edge.
    initial begin
        exp_t e;
        bit   k;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1) begin
                if (resolved === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_resolved: got resolved=1 with no branch pending (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("taken", {31'd0, taken}, {31'd0, e.tk});
                        chk("redirect", {31'd0, redirect}, {31'd0, e.tk});
                        if (e.tk) chk("target", target, e.tgt);
                        chk("latency", cyc, e.at);
                    end
                end else begin
                    chk("redirect_quiet", {31'd0, redirect}, 32'd0);
                end
                if (slot_chk) begin
                    k = (kill_q.size() != 0) ? kill_q.pop_front() : 1'b0;
                    chk("slot_kill", {31'd0, slot_kill}, {31'd0, k});
                end else begin
                    chk("slot_kill_quiet", {31'd0, slot_kill}, 32'd0);
                end
            end
        end
    end

    task automatic set_icc(input bit [3:0] v);
        @(negedge clk);
        br_valid = 1'b0; slot_issue = 1'b0; slot_chk = 1'b0; flush = 1'b0;
        icc_we = 1'b1; icc_in = v; icc_m = v;
        @(negedge clk);
        icc_we = 1'b0;
        chk("icc", {28'd0, icc}, {28'd0, v});
    endtask

    task automatic run_branch(input bit [3:0] c, input bit a, input bit [21:0] d, input bit [31:0] p,
                              input bit we0, input bit [3:0] icc0, input bit we1, input bit [3:0] icc1,
                              input bit rs_slot, input int dly, input bit fl);
        int   hs;
        int   w;
        bit   tk;
        bit   k;
        exp_t e;
        w = 0;
        @(negedge clk);
        flush = 1'b0; slot_issue = 1'b0; slot_chk = 1'b0; icc_we = 1'b0; br_valid = 1'b0;
        while (br_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: br_ready=%b after %0d cycles, expected 1", br_ready, w);
            return;
        end
        br_valid = 1'b1; cond = c; annul = a; disp = d; pc = p;
        icc_we = we0; icc_in = icc0;
        if (we0) icc_m = icc0;
        hs = cyc + 1;
        @(negedge clk);
        chk("busy", {31'd0, br_ready}, 32'd0);
        br_valid = 1'($urandom_range(0, 1));
        cond = 4'($urandom); annul = 1'($urandom); disp = 22'($urandom); pc = $urandom;
        if (we0) begin
            icc_we = we1; icc_in = icc1;
            if (we1) icc_m = icc1;
            tk = ref_taken(c, icc_m);
            e.tk = tk; e.tgt = ref_target(p, d); e.at = hs + 1;
            exp_q.push_back(e);
            @(negedge clk);
        end else begin
            tk = ref_taken(c, icc_m);
            e.tk = tk; e.tgt = ref_target(p, d); e.at = hs;
            exp_q.push_back(e);
        end
        // RESOLVE cycle: a late flag write or early slot_issue must not disturb it.
        icc_we = 1'($urandom_range(0, 1)); icc_in = 4'($urandom);
        if (icc_we) icc_m = icc_in;
        slot_issue = rs_slot;
        k = a && (!tk || c == 4'h8);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            icc_we = 1'b0; slot_issue = 1'b0; br_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        icc_we = 1'b0; br_valid = 1'b0; slot_issue = 1'b1;
        if (fl) begin
            flush = 1'b1; slot_chk = 1'b0;
        end else begin
            slot_chk = 1'b1; kill_q.push_back(k);
        end
        @(negedge clk);
        slot_issue = 1'b0; flush = 1'b0; slot_chk = 1'b0;
        chk("ready_after_slot", {31'd0, br_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; icc_we = 1'b0; icc_in = 4'd0; br_valid = 1'b0; cond = 4'd0;
        annul = 1'b0; disp = 22'd0; pc = 32'd0; slot_issue = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_icc", {28'd0, icc}, 32'd0);
        chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_resolved", {31'd0, resolved}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_slot_kill", {31'd0, slot_kill}, 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        set_icc(4'b0100);
        run_branch(4'h1, 1'b0, 22'h000004, 32'h100, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 0, 1'b0);
        set_icc(4'b0000);
        run_branch(4'h9, 1'b1, 22'h3FFFFF, 32'h200, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1, 1'b0);
        set_icc(4'b0000);
        run_branch(4'h1, 1'b1, 22'h000010, 32'h300, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2, 1'b0);
        set_icc(4'b0000);
        run_branch(4'h8, 1'b1, 22'h000020, 32'h400, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 0, 1'b0);
        set_icc(4'b0000);
        run_branch(4'h0, 1'b0, 22'h000020, 32'h500, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 0, 1'b0);
        set_icc(4'b0000);
        run_branch(4'h0, 1'b1, 22'h000020, 32'h600, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1, 1'b0);
        set_icc(4'b0000);
        run_branch(4'h3, 1'b0, 22'h000008, 32'h700, 1'b1, 4'b1000, 1'b0, 4'd0, 1'b0, 0, 1'b0);
        set_icc(4'b0000);
        run_branch(4'h3, 1'b0, 22'h000008, 32'h700, 1'b1, 4'b1010, 1'b0, 4'd0, 1'b0, 0, 1'b0);
        set_icc(4'b0000);
        run_branch(4'h3, 1'b1, 22'h000008, 32'h700, 1'b1, 4'b0000, 1'b1, 4'b1000, 1'b0, 0, 1'b0);
        run_branch(4'h8, 1'b0, 22'h000001, 32'hFFFFFFFC, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 0, 1'b0);

        // Full cond x icc sweep.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                set_icc(4'(f));
                run_branch(4'(c), 1'($urandom), 22'($urandom), $urandom, 1'b0, 4'd0, 1'b0, 4'd0,
                           1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
            end
        end

        // Random traffic including flag hazards.
        repeat (150) begin
            run_branch(4'($urandom), 1'($urandom), 22'($urandom), $urandom,
                       1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        // Flush in SLOT with an annulled slot pending.
        set_icc(4'b0000);
        run_branch(4'h8, 1'b1, 22'h000040, 32'h800, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1, 1'b1);
        run_branch(4'h0, 1'b1, 22'h000004, 32'h900, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 0, 1'b0);

        // Reset while waiting in CCWAIT, after a taken branch left taken/target set.
        run_branch(4'h8, 1'b0, 22'h000100, 32'hA00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 0, 1'b0);
        @(negedge clk);
        br_valid = 1'b1; cond = 4'h3; annul = 1'b0; disp = 22'd4; pc = 32'hB00;
        icc_we = 1'b1; icc_in = 4'b1000;
        @(negedge clk);
        br_valid = 1'b0; icc_we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_icc", {28'd0, icc}, 32'd0);
        chk("mid_rst_br_ready", {31'd0, br_ready}, 32'd1);
        chk("mid_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("mid_rst_resolved", {31'd0, resolved}, 32'd0);
        chk("mid_rst_taken", {31'd0, taken}, 32'd0);
        chk("mid_rst_target", target, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; icc_m = 4'b0000;
        repeat (5) @(negedge clk);

        chk("pending_branches", exp_q.size(), 32'd0);
        chk("pending_slots", kill_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
